// File: rtl/mc_controller.sv
// Multi-cycle sequencer for the 19-bit ISA over a shared memory port.
// Steps the latched IR through DECODE/EXEC/MEM/WB and traps call-stack misuse.
module mc_controller #(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        zero,
  input  logic        carry,
  output logic        mem_req,
  output logic        mem_read_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg2_read_source,
  output logic        alu_src,
  output logic        mem_or_alu,
  output logic        is_shift,
  output logic        reg_write_signal,
  output logic [2:0]  acode,
  output logic [1:0]  scode,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [18:0]        ir_q;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  logic c_alu, c_sh, c_mem, c_br, c_jmp, c_ret;
  logic ld, mem_acc, br_taken, full, empty;

  assign c_alu   = ~ir_q[18];
  assign c_sh    = ir_q[18:16] == 3'b110;
  assign c_mem   = ir_q[18:16] == 3'b100;
  assign c_br    = ir_q[18:16] == 3'b101;
  assign c_jmp   = ir_q[18:15] == 4'b1110;
  assign c_ret   = ir_q[18:13] == 6'b111100;
  assign ld      = c_mem & (ir_q[15:14] == 2'b00);
  assign mem_acc = c_mem & ~ir_q[15];
  assign full    = depth_q == DEPTH_W'(STACK_DEPTH);
  assign empty   = depth_q == '0;

  // Condition select: bit 15 picks the flag, bit 14 inverts it.
  assign br_taken = (ir_q[15] ? carry : zero) ^ ir_q[14];

  assign state = state_q;

  always_comb begin
    state_d          = state_q;
    depth_d          = depth_q;
    mem_req          = 1'b0;
    mem_read_write   = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 2'b00;
    reg2_read_source = 1'b0;
    alu_src          = 1'b0;
    mem_or_alu       = 1'b0;
    is_shift         = 1'b0;
    reg_write_signal = 1'b0;
    acode            = 3'b000;
    scode            = 2'b00;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    halted           = 1'b0;
    fault            = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = (&ir_q) ? S_HALT : S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (1'b1)
          c_alu: begin
            acode   = ir_q[16:14];
            alu_src = ir_q[17];
            state_d = S_WB;
          end
          c_sh: begin
            is_shift = 1'b1;
            scode    = ir_q[15:14];
            state_d  = S_WB;
          end
          c_mem: begin
            alu_src          = 1'b1;
            reg2_read_source = 1'b1;
            state_d          = S_MEM;
          end
          c_br: begin
            pc_write = br_taken;
            pc_src   = br_taken ? 2'b01 : 2'b00;
          end
          c_jmp: begin
            if (ir_q[14] && full) begin
              state_d = S_FAULT;
            end else begin
              pc_write   = 1'b1;
              pc_src     = 2'b01;
              stack_push = ir_q[14];
              depth_d    = depth_q + DEPTH_W'(ir_q[14]);
            end
          end
          c_ret: begin
            if (empty) begin
              state_d = S_FAULT;
            end else begin
              pc_write  = 1'b1;
              pc_src    = 2'b10;
              stack_pop = 1'b1;
              depth_d   = depth_q - 1'b1;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_src          = 1'b1;
        reg2_read_source = 1'b1;
        if (mem_acc) begin
          mem_req        = 1'b1;
          mem_read_write = ir_q[14];
          if (mem_ready) state_d = ld ? S_WB : S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        // Keep the ALU/shifter selects from EXEC so the result is stable.
        reg_write_signal = 1'b1;
        mem_or_alu       = ~ld;
        acode            = c_alu ? ir_q[16:14] : 3'b000;
        alu_src          = (c_alu & ir_q[17]) | c_mem;
        is_shift         = c_sh;
        scode            = c_sh ? ir_q[15:14] : 2'b00;
        state_d          = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      if (ir_write) ir_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Random instruction stream checked cycle by cycle against a
// transaction-level model of the multi-cycle sequencer.
module tb_mc_controller;

  localparam int SD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] mem_rdata;
  logic        mem_ready;
  logic        zero, carry;
  logic        mem_req, mem_read_write, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg2_read_source, alu_src, mem_or_alu, is_shift;
  logic        reg_write_signal;
  logic [2:0]  acode;
  logic [1:0]  scode;
  logic        stack_push, stack_pop, halted, fault;
  logic [2:0]  state;

  int n_chk = 0;
  int n_err = 0;
  int m_depth = 0;

  mc_controller #(.STACK_DEPTH(SD), .DEPTH_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .zero(zero), .carry(carry),
    .mem_req(mem_req), .mem_read_write(mem_read_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg2_read_source(reg2_read_source), .alu_src(alu_src),
    .mem_or_alu(mem_or_alu), .is_shift(is_shift),
    .reg_write_signal(reg_write_signal),
    .acode(acode), .scode(scode),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    m_depth = 0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_req", mem_req, 1);
    chk("rst_pcw", pc_write, 0);
    chk("rst_regw", reg_write_signal, 0);
  endtask

  task automatic run(input logic [18:0] ir, input int fd, input int md,
                     input logic z, input logic c);
    logic e_pcw, e_push, e_pop, e_as, e_sh, e_r2, ld, taken;
    logic [1:0] e_src, e_sc;
    logic [2:0] e_ac;
    int nxt;
    for (int i = 0; i <= fd; i++) begin
      mem_rdata = (i == fd) ? ir : 19'($urandom);
      mem_ready = (i == fd);
      #1;
      chk("f_state", state, 0);
      chk("f_req", mem_req, 1);
      chk("f_rw", mem_read_write, 0);
      chk("f_irw", ir_write, i == fd);
      chk("f_pcw", pc_write, i == fd);
      chk("f_src", pc_src, 0);
      tick();
    end
    mem_ready = 1'($urandom);
    #1;
    chk("d_state", state, 1);
    chk("d_req", mem_req, 0);
    chk("d_pcw", pc_write, 0);
    tick();
    if (ir == 19'h7FFFF) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        chk("h_state", state, 5);
        chk("h_halted", halted, 1);
        chk("h_req", mem_req, 0);
        tick();
      end
      do_reset();
      return;
    end
    zero = z;
    carry = c;
    e_pcw = 0; e_push = 0; e_pop = 0; e_as = 0; e_sh = 0; e_r2 = 0;
    e_src = 0; e_sc = 0; e_ac = 0; nxt = 0;
    ld = (ir[18:16] == 3'b100) && (ir[15:14] == 2'b00);
    if (!ir[18]) begin
      e_ac = ir[16:14]; e_as = ir[17]; nxt = 4;
    end else if (ir[18:16] == 3'b110) begin
      e_sh = 1; e_sc = ir[15:14]; nxt = 4;
    end else if (ir[18:16] == 3'b100) begin
      e_as = 1; e_r2 = 1; nxt = 3;
    end else if (ir[18:16] == 3'b101) begin
      case (ir[15:14])
        2'd0: taken = z;
        2'd1: taken = !z;
        2'd2: taken = c;
        default: taken = !c;
      endcase
      e_pcw = taken;
      e_src = taken ? 2'b01 : 2'b00;
    end else if (ir[18:15] == 4'b1110) begin
      if (ir[14] && m_depth == SD) nxt = 6;
      else begin
        e_pcw = 1; e_src = 2'b01; e_push = ir[14];
        if (ir[14]) m_depth++;
      end
    end else if (ir[18:13] == 6'b111100) begin
      if (m_depth == 0) nxt = 6;
      else begin
        e_pcw = 1; e_src = 2'b10; e_pop = 1; m_depth--;
      end
    end
    #1;
    chk("e_state", state, 2);
    chk("e_pcw", pc_write, e_pcw);
    chk("e_src", pc_src, e_src);
    chk("e_push", stack_push, e_push);
    chk("e_pop", stack_pop, e_pop);
    chk("e_acode", acode, e_ac);
    chk("e_asrc", alu_src, e_as);
    chk("e_shift", is_shift, e_sh);
    chk("e_scode", scode, e_sc);
    chk("e_r2", reg2_read_source, e_r2);
    chk("e_req", mem_req, 0);
    chk("e_regw", reg_write_signal, 0);
    tick();
    if (nxt == 6) begin
      for (int i = 0; i < 2; i++) begin
        #1;
        chk("x_state", state, 6);
        chk("x_fault", fault, 1);
        chk("x_pcw", pc_write, 0);
        chk("x_push", stack_push, 0);
        chk("x_pop", stack_pop, 0);
        tick();
      end
      do_reset();
      return;
    end
    if (nxt == 3) begin
      if (ir[15]) begin
        #1;
        chk("m_state", state, 3);
        chk("m_req", mem_req, 0);
        chk("m_asrc", alu_src, 1);
        tick();
      end else begin
        for (int i = 0; i <= md; i++) begin
          mem_ready = (i == md);
          #1;
          chk("m_state", state, 3);
          chk("m_req", mem_req, 1);
          chk("m_rw", mem_read_write, ir[14]);
          chk("m_asrc", alu_src, 1);
          chk("m_r2", reg2_read_source, 1);
          chk("m_regw", reg_write_signal, 0);
          tick();
        end
        if (ld) nxt = 4;
      end
    end
    if (nxt == 4) begin
      #1;
      chk("w_state", state, 4);
      chk("w_regw", reg_write_signal, 1);
      chk("w_moa", mem_or_alu, !ld);
      chk("w_acode", acode, e_ac);
      chk("w_asrc", alu_src, e_as);
      chk("w_shift", is_shift, e_sh);
      chk("w_pcw", pc_write, 0);
      chk("w_req", mem_req, 0);
      tick();
    end
  endtask

  function automatic logic [18:0] rand_ir();
    case ($urandom_range(0, 9))
      0: return {2'b00, 17'($urandom)};
      1: return {2'b01, 17'($urandom)};
      2: return {3'b110, 16'($urandom)};
      3: return {3'b100, 16'($urandom)};
      4: return {3'b101, 16'($urandom)};
      5: return {4'b1110, 15'($urandom)};
      6: return {6'b111100, 13'($urandom)};
      7: return {6'b111101, 13'($urandom)};
      8: return {5'b11101, 14'($urandom)};
      default: return ($urandom_range(0, 3) == 0) ? 19'h7FFFF
                                                   : {2'b00, 17'($urandom)};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    mem_rdata = '0;
    mem_ready = 1'b0;
    zero = 1'b0;
    carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_state", state, 0);
    chk("init_req", mem_req, 1);
    chk("init_irw", ir_write, 0);
    chk("init_flags", {halted, fault}, 0);
    run({5'b00010, 14'h1234}, 0, 0, 0, 0);
    run({5'b10000, 14'h0055}, 3, 3, 0, 0);
    run({5'b10001, 14'h0055}, 3, 3, 0, 0);
    run({5'b10101, 14'h0000}, 0, 0, 0, 0);
    run({5'b10101, 14'h0000}, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) run({5'b11101, 14'h0010}, 0, 0, 0, 0);
    run({6'b111100, 13'h0}, 0, 0, 0, 0);
    run({5'b11101, 14'h0001}, 0, 0, 0, 0);
    run({6'b111100, 13'h0}, 0, 0, 0, 0);
    run(19'h7FFFF, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      run(rand_ir(), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
